// File: rtl/ddram_arb_pkg.sv
// Shared types for the DDR3 port arbiter: FSM states, captured request slot, helpers.
package ddram_arb_pkg;

  localparam int NUM_CH_MAX = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [27:1] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        is16;
  } req_t;

  function automatic int wrap_inc(int idx, int num);
    return (idx >= num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ddram_arbiter_if.sv
// Client-side and bridge-side bus of the DDR3 arbiter. slave = arbiter view,
// master = the surrounding clients plus bridge.
interface ddram_arbiter_if #(parameter int NUM_CH = 3);

  logic [NUM_CH-1:0][27:1] ch_addr;
  logic [NUM_CH-1:0][31:0] ch_din;
  logic [NUM_CH-1:0]       ch_rd;
  logic [NUM_CH-1:0][3:0]  ch_wr;
  logic [NUM_CH-1:0]       ch_16b;
  logic [NUM_CH-1:0][31:0] ch_dout;
  logic [NUM_CH-1:0]       ch_busy;

  logic [27:1] ddr_addr;
  logic [31:0] ddr_din;
  logic        ddr_rd;
  logic [3:0]  ddr_wr;
  logic        ddr_16b;
  logic [31:0] ddr_dout;
  logic        ddr_busy;

  modport slave (
    input  ch_addr, ch_din, ch_rd, ch_wr, ch_16b, ddr_dout, ddr_busy,
    output ch_dout, ch_busy, ddr_addr, ddr_din, ddr_rd, ddr_wr, ddr_16b
  );

  modport master (
    output ch_addr, ch_din, ch_rd, ch_wr, ch_16b, ddr_dout, ddr_busy,
    input  ch_dout, ch_busy, ddr_addr, ddr_din, ddr_rd, ddr_wr, ddr_16b
  );

endinterface

// File: rtl/ddram_arb_pick.sv
// Combinational grant picker: round-robin from rr, or fixed priority (channel 0
// highest) when DDRAM_ARB_FIXED_PRIO_EN is defined.
module ddram_arb_pick
  import ddram_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [CH_W-1:0]   rr,
  output logic [CH_W-1:0]   gnt,
  output logic              vld
);

`ifdef DDRAM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        gnt = CH_W'(i);
        vld = 1'b1;
      end
    end
  end
`else
  // Scan offsets high to low so the smallest offset from rr is the last writer.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pend[idx]) begin
        gnt = CH_W'(idx);
        vld = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ddram_arbiter.sv
// Shares one edge-triggered DDR3 bridge port between NUM_CH identical clients.
// Define DDRAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2
) (
  input logic            clk,
  input logic            rst,
  ddram_arbiter_if.slave bus
);

  if (NUM_CH < 2 || NUM_CH > NUM_CH_MAX) begin : g_bad_cfg
    $error("ddram_arbiter: NUM_CH out of range");
  end

  // ---------------- per-channel capture ----------------
  logic [NUM_CH-1:0] rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [NUM_CH-1:0] rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [NUM_CH-1:0] rd_edge, wr_edge, busy_vec, clr_rd, clr_wr;
  req_t [NUM_CH-1:0] slot_q, slot_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) wr_prev_d[i] = |bus.ch_wr[i];
  end

  assign rd_prev_d = bus.ch_rd;
  assign rd_edge   = bus.ch_rd & ~rd_prev_q;
  assign wr_edge   = wr_prev_d & ~wr_prev_q;
  assign busy_vec  = rd_pend_q | wr_pend_q;

  // A channel with anything outstanding ignores new edges; a simultaneous rd+wr
  // edge shares one slot and is serviced write-first.
  always_comb begin
    slot_d    = slot_q;
    rd_pend_d = rd_pend_q & ~clr_rd;
    wr_pend_d = wr_pend_q & ~clr_wr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!busy_vec[i] && (rd_edge[i] || wr_edge[i])) begin
        slot_d[i].addr = bus.ch_addr[i];
        slot_d[i].din  = bus.ch_din[i];
        slot_d[i].be   = bus.ch_wr[i];
        slot_d[i].is16 = bus.ch_16b[i];
        rd_pend_d[i]   = rd_edge[i];
        wr_pend_d[i]   = wr_edge[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev_q <= '0;
      wr_prev_q <= '0;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      slot_q    <= '0;
    end else begin
      rd_prev_q <= rd_prev_d;
      wr_prev_q <= wr_prev_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      slot_q    <= slot_d;
    end
  end

  // ---------------- grant ----------------
  state_t                  state_q;
  logic [CH_W-1:0]         gnt_q, pick_gnt, rr_ptr;
  logic                    pick_vld, is_wr_q;
  logic [27:1]             ddr_addr_q;
  logic [31:0]             ddr_din_q;
  logic                    ddr_rd_q, ddr_16b_q;
  logic [3:0]              ddr_wr_q;
  logic [NUM_CH-1:0][31:0] ch_dout_q;

`ifdef DDRAM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [CH_W-1:0] rr_q;
  assign rr_ptr = rr_q;
`endif

  ddram_arb_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .pend (busy_vec),
    .rr   (rr_ptr),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  always_comb begin
    clr_rd = '0;
    clr_wr = '0;
    if (state_q == DONE) begin
      if (is_wr_q) clr_wr[gnt_q] = 1'b1;
      else         clr_rd[gnt_q] = 1'b1;
    end
  end

  // ---------------- bridge FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      is_wr_q    <= 1'b0;
      ddr_addr_q <= '0;
      ddr_din_q  <= '0;
      ddr_rd_q   <= 1'b0;
      ddr_wr_q   <= '0;
      ddr_16b_q  <= 1'b0;
      ch_dout_q  <= '0;
`ifndef DDRAM_ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Bridge must be idle too, which also covers a reset mid-transaction.
          if (pick_vld && !bus.ddr_busy) begin
            gnt_q      <= pick_gnt;
            is_wr_q    <= wr_pend_q[pick_gnt];
            ddr_addr_q <= slot_q[pick_gnt].addr;
            ddr_din_q  <= slot_q[pick_gnt].din;
            ddr_16b_q  <= slot_q[pick_gnt].is16;
            if (wr_pend_q[pick_gnt]) ddr_wr_q <= slot_q[pick_gnt].be;
            else                     ddr_rd_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.ddr_busy) begin
            ddr_rd_q <= 1'b0;
            ddr_wr_q <= '0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.ddr_busy) state_q <= DONE;
        end
        DONE: begin
          if (!is_wr_q) ch_dout_q[gnt_q] <= bus.ddr_dout;
`ifndef DDRAM_ARB_FIXED_PRIO_EN
          rr_q <= CH_W'(wrap_inc(int'(gnt_q), NUM_CH));
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ch_dout  = ch_dout_q;
  assign bus.ch_busy  = busy_vec;
  assign bus.ddr_addr = ddr_addr_q;
  assign bus.ddr_din  = ddr_din_q;
  assign bus.ddr_rd   = ddr_rd_q;
  assign bus.ddr_wr   = ddr_wr_q;
  assign bus.ddr_16b  = ddr_16b_q;

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench for ddram_arbiter with a behavioural edge-triggered bridge model.
module tb_ddram_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddram_arbiter_if #(.NUM_CH(N)) bus();
  ddram_arbiter #(.NUM_CH(N), .CH_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errs = 0;
  int checks = 0;

  // ---------------- bridge model ----------------
  logic [31:0] mem [int];
  int          blen = 3;
  int          cnt = 0;
  bit          model_init = 0;
  logic        rd_prv = 1'b0, wr_prv = 1'b0;
  int          log_addr[$];
  bit          log_wr[$];
  logic [3:0]  log_be[$];
  logic        log_16b[$];
  logic [31:0] log_din[$];

  always @(negedge clk) begin
    int a;
    logic [31:0] w;
    if (!model_init) begin
      bus.ddr_busy = 1'b0;
      bus.ddr_dout = '0;
      model_init   = 1;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) bus.ddr_busy = 1'b0;
    end
    a = int'(bus.ddr_addr);
    if (bus.ddr_rd && !rd_prv) begin
      log_addr.push_back(a); log_wr.push_back(0); log_be.push_back(bus.ddr_wr);
      log_16b.push_back(bus.ddr_16b); log_din.push_back(bus.ddr_din);
      bus.ddr_dout = mem.exists(a) ? mem[a] : 32'h0;
      cnt = blen;
      bus.ddr_busy = 1'b1;
    end else if ((|bus.ddr_wr) && !wr_prv) begin
      log_addr.push_back(a); log_wr.push_back(1); log_be.push_back(bus.ddr_wr);
      log_16b.push_back(bus.ddr_16b); log_din.push_back(bus.ddr_din);
      w = mem.exists(a) ? mem[a] : 32'h0;
      for (int b = 0; b < 4; b++) if (bus.ddr_wr[b]) w[8*b +: 8] = bus.ddr_din[8*b +: 8];
      mem[a] = w;
      cnt = blen;
      bus.ddr_busy = 1'b1;
    end
    rd_prv = bus.ddr_rd;
    wr_prv = |bus.ddr_wr;
  end

  // ---------------- helpers ----------------
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(int c, logic rd, logic [3:0] be, logic [26:0] a, logic [31:0] d, logic h16);
    bus.ch_addr[c] = a;
    bus.ch_din[c]  = d;
    bus.ch_16b[c]  = h16;
    bus.ch_rd[c]   = rd;
    bus.ch_wr[c]   = be;
  endtask

  task automatic drop_all();
    bus.ch_rd = '0;
    bus.ch_wr = '0;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wr.delete(); log_be.delete(); log_16b.delete(); log_din.delete();
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (bus.ch_busy !== '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 400), 64'd1);
  endtask

  task automatic wait_log(int k, string tag);
    int n = 0;
    while (log_addr.size() < k && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 200), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  seen;
    int  exp_order[3];
    rst         = 1'b1;
    bus.ch_addr = '0;
    bus.ch_din  = '0;
    bus.ch_rd   = '0;
    bus.ch_wr   = '0;
    bus.ch_16b  = '0;
    mem[32'h10]  = 32'h11111111;
    mem[32'h20]  = 32'h22222222;
    mem[32'h30]  = 32'h33333333;
    mem[32'h100] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);

    chk("rst_ch_busy", 64'(bus.ch_busy), 64'd0);
    chk("rst_strobes", 64'({bus.ddr_rd, bus.ddr_wr}), 64'd0);
    chk("rst_ddr_addr", 64'(bus.ddr_addr), 64'd0);
    chk("rst_ch_dout", 64'(bus.ch_dout == '0), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // three simultaneous reads, rr pointer at 0
    req(0, 1, 4'h0, 27'h10, 0, 0);
    req(1, 1, 4'h0, 27'h20, 0, 0);
    req(2, 1, 4'h0, 27'h30, 0, 0);
    @(negedge clk);
    chk("busy_after_edge", 64'(bus.ch_busy), 64'h7);
    drop_all();
    wait_idle("rr0_idle");
    chk("rr0_count", 64'(log_addr.size()), 64'd3);
    if (log_addr.size() == 3) begin
      chk("rr0_first", 64'(log_addr[0]), 64'h10);
      chk("rr0_second", 64'(log_addr[1]), 64'h20);
      chk("rr0_third", 64'(log_addr[2]), 64'h30);
    end
    chk("rr0_dout0", 64'(bus.ch_dout[0]), 64'h11111111);
    chk("rr0_dout2", 64'(bus.ch_dout[2]), 64'h33333333);
    clear_log();

    // single read on ch1
    req(1, 1, 4'h0, 27'h100, 0, 0);
    @(negedge clk);
    chk("rd1_busy", 64'(bus.ch_busy), 64'h2);
    drop_all();
    wait_idle("rd1_idle");
    chk("rd1_dout", 64'(bus.ch_dout[1]), 64'hDEADBEEF);
    chk("rd1_edges", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() == 1) chk("rd1_addr", 64'(log_addr[0]), 64'h100);
    clear_log();

    // single 16-bit write on ch0
    req(0, 0, 4'b0011, 27'h2, 32'h1234, 1);
    @(negedge clk);
    drop_all();
    bus.ch_16b = '0;
    wait_idle("wr0_idle");
    chk("wr0_count", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() == 1) begin
      chk("wr0_is_wr", 64'(log_wr[0]), 64'd1);
      chk("wr0_be", 64'(log_be[0]), 64'h3);
      chk("wr0_16b", 64'(log_16b[0]), 64'd1);
      chk("wr0_din", 64'(log_din[0]), 64'h00001234);
      chk("wr0_addr", 64'(log_addr[0]), 64'h2);
    end
    clear_log();

    // three simultaneous reads again; last grant was ch0 so rr is 1
`ifdef DDRAM_ARB_FIXED_PRIO_EN
    exp_order = '{32'h10, 32'h20, 32'h30};
`else
    exp_order = '{32'h20, 32'h30, 32'h10};
`endif
    req(0, 1, 4'h0, 27'h10, 0, 0);
    req(1, 1, 4'h0, 27'h20, 0, 0);
    req(2, 1, 4'h0, 27'h30, 0, 0);
    @(negedge clk);
    drop_all();
    wait_idle("rr1_idle");
    chk("rr1_count", 64'(log_addr.size()), 64'd3);
    if (log_addr.size() == 3) begin
      chk("rr1_first", 64'(log_addr[0]), 64'(exp_order[0]));
      chk("rr1_second", 64'(log_addr[1]), 64'(exp_order[1]));
      chk("rr1_third", 64'(log_addr[2]), 64'(exp_order[2]));
    end
    clear_log();

    // ch2 read and write edges in the same cycle
    req(2, 1, 4'hF, 27'h40, 32'hA5A5A5A5, 0);
    @(negedge clk);
    drop_all();
    wait_idle("rw2_idle");
    chk("rw2_count", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("rw2_first_wr", 64'(log_wr[0]), 64'd1);
      chk("rw2_second_rd", 64'(log_wr[1]), 64'd0);
      chk("rw2_addr", 64'(log_addr[1]), 64'h40);
    end
    chk("rw2_dout", 64'(bus.ch_dout[2]), 64'hA5A5A5A5);
    clear_log();

    // long bridge busy: strobes stay low, no second grant
    blen = 20;
    req(0, 1, 4'h0, 27'h10, 0, 0);
    req(1, 1, 4'h0, 27'h20, 0, 0);
    @(negedge clk);
    drop_all();
    wait_log(1, "busy_first_grant");
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.ddr_rd || (|bus.ddr_wr)) seen++;
      @(negedge clk);
    end
    chk("busy_strobe_low", 64'(seen), 64'd0);
    chk("busy_no_second", 64'(log_addr.size()), 64'd1);
    wait_idle("busy_idle");
    chk("busy_both_served", 64'(log_addr.size()), 64'd2);
    clear_log();

    // reset while the bridge is busy
    req(0, 1, 4'h0, 27'h30, 0, 0);
    @(negedge clk);
    drop_all();
    wait_log(1, "mid_grant");
    repeat (3) @(negedge clk);
    chk("mid_pre_busy", 64'(bus.ddr_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", 64'(bus.ddr_rd), 64'd0);
    chk("mid_rst_busy", 64'(bus.ch_busy), 64'd0);
    chk("mid_rst_addr", 64'(bus.ddr_addr), 64'd0);
    chk("mid_rst_dout", 64'(bus.ch_dout == '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    req(1, 1, 4'h0, 27'h20, 0, 0);
    @(negedge clk);
    drop_all();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ddr_rd) seen++;
      @(negedge clk);
    end
    chk("mid_no_grant", 64'(seen), 64'd0);
    chk("mid_bridge_busy", 64'(bus.ddr_busy), 64'd1);
    wait_idle("mid_idle");
    chk("mid_count", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) chk("mid_addr", 64'(log_addr[1]), 64'h20);
    chk("mid_dout", 64'(bus.ch_dout[1]), 64'h22222222);
    chk("mid_ch0_dropped", 64'(bus.ch_dout[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
